// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the clock-divider ratio controller.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATE,
    ST_LOAD,
    ST_RESUME
  } clkdiv_ctrl_state_t;

  localparam int CLKDIV_BYPASS_RATIO = 1;
  localparam int CLKDIV_GUARD_CYCLES = 4;
  localparam int CLKDIV_GUARD_W      = 8;

endpackage

// File: rtl/clkdiv_guard_cnt.sv
// 8-bit loadable down-counter that holds at zero; shared by the GATE and RESUME guards.
module clkdiv_guard_cnt
  import clkdiv_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      load,
  input  logic [CLKDIV_GUARD_W-1:0] load_val,
  output logic                      zero
);

  logic [CLKDIV_GUARD_W-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/clkdiv_ratio_ctrl.sv
// Sequences glitch-safe ratio changes for the integer clock divider:
// gate, load ratio with counter restart, resume, then report completion.
module clkdiv_ratio_ctrl
  import clkdiv_pkg::*;
#(
  parameter int RATIO_WIDTH   = 8,
  parameter int GUARD_CYCLES  = CLKDIV_GUARD_CYCLES,
  parameter int DEFAULT_RATIO = CLKDIV_BYPASS_RATIO
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CFG_VALID,
  input  logic [RATIO_WIDTH-1:0] CFG_RATIO,
  output logic                   CFG_READY,
  input  logic                   EN_REQ,
  output logic [RATIO_WIDTH-1:0] DIV_RATIO,
  output logic                   DIV_CLK_EN,
  output logic                   DIV_CNT_RST_N,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam logic [RATIO_WIDTH-1:0]    RST_RATIO  = RATIO_WIDTH'(DEFAULT_RATIO);
  localparam logic [CLKDIV_GUARD_W-1:0] GUARD_LOAD = CLKDIV_GUARD_W'(GUARD_CYCLES - 1);

  // Ratio 0 and 1 both mean bypass; fold 0 onto 1 so compares see one encoding.
  function automatic logic [RATIO_WIDTH-1:0] norm_ratio(input logic [RATIO_WIDTH-1:0] r);
    return (r == '0) ? RATIO_WIDTH'(CLKDIV_BYPASS_RATIO) : r;
  endfunction

  clkdiv_ctrl_state_t     state_q, state_nxt;
  logic [RATIO_WIDTH-1:0] ratio_q, ratio_nxt;
  logic [RATIO_WIDTH-1:0] pend_q;
  logic [RATIO_WIDTH-1:0] cfg_norm;
  logic                   clk_en_q, clk_en_nxt;
  logic                   cnt_rst_n_q, cnt_rst_n_nxt;
  logic                   busy_q, busy_nxt;
  logic                   done_q, done_nxt;
  logic                   ready_q, ready_nxt;
  logic                   accept;
  logic                   pend_load;
  logic                   guard_load;
  logic                   guard_zero;

  assign cfg_norm = norm_ratio(CFG_RATIO);
  assign accept   = CFG_VALID && ready_q;

  clkdiv_guard_cnt u_guard (
    .CLK      (CLK),
    .RST      (RST),
    .load     (guard_load),
    .load_val (GUARD_LOAD),
    .zero     (guard_zero)
  );

  always_comb begin
    state_nxt     = state_q;
    ratio_nxt     = ratio_q;
    clk_en_nxt    = clk_en_q;
    cnt_rst_n_nxt = 1'b1;
    busy_nxt      = busy_q;
    done_nxt      = 1'b0;
    ready_nxt     = ready_q;
    pend_load     = 1'b0;
    guard_load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_nxt  = 1'b1;
        busy_nxt   = 1'b0;
        clk_en_nxt = EN_REQ;
        if (accept) begin
          if (cfg_norm == ratio_q) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt  = ST_GATE;
            ready_nxt  = 1'b0;
            busy_nxt   = 1'b1;
            clk_en_nxt = 1'b0;
            pend_load  = 1'b1;
            guard_load = 1'b1;
          end
        end
      end
      ST_GATE: begin
        clk_en_nxt = 1'b0;
        if (guard_zero) begin
          state_nxt     = ST_LOAD;
          ratio_nxt     = pend_q;
          cnt_rst_n_nxt = 1'b0;
        end
      end
      ST_LOAD: begin
        state_nxt  = ST_RESUME;
        clk_en_nxt = EN_REQ;
        guard_load = 1'b1;
      end
      ST_RESUME: begin
        clk_en_nxt = EN_REQ;
        if (guard_zero) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
          ready_nxt = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered control and divider-facing outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      ratio_q     <= RST_RATIO;
      clk_en_q    <= 1'b0;
      cnt_rst_n_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      ratio_q     <= ratio_nxt;
      clk_en_q    <= clk_en_nxt;
      cnt_rst_n_q <= cnt_rst_n_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
      ready_q     <= ready_nxt;
    end
  end

  // Pending ratio is pure data and is only consumed after a fresh accept
  always_ff @(posedge CLK) begin
    if (pend_load) begin
      pend_q <= cfg_norm;
    end
  end

  assign DIV_RATIO     = ratio_q;
  assign DIV_CLK_EN    = clk_en_q;
  assign DIV_CNT_RST_N = cnt_rst_n_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign CFG_READY     = ready_q;

endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
// Scenario bench for clkdiv_ratio_ctrl against a cycle-timeline model of the reconfiguration sequence.
module tb_clkdiv_ratio_ctrl;

  localparam int G = 4;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         CFG_VALID = 1'b0;
  logic [W-1:0] CFG_RATIO = '0;
  logic         CFG_READY;
  logic         EN_REQ = 1'b0;
  logic [W-1:0] DIV_RATIO;
  logic         DIV_CLK_EN;
  logic         DIV_CNT_RST_N;
  logic         BUSY;
  logic         DONE;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] model_ratio = 8'd1;

  clkdiv_ratio_ctrl #(.RATIO_WIDTH(W), .GUARD_CYCLES(G), .DEFAULT_RATIO(1)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .CFG_VALID     (CFG_VALID),
    .CFG_RATIO     (CFG_RATIO),
    .CFG_READY     (CFG_READY),
    .EN_REQ        (EN_REQ),
    .DIV_RATIO     (DIV_RATIO),
    .DIV_CLK_EN    (DIV_CLK_EN),
    .DIV_CNT_RST_N (DIV_CNT_RST_N),
    .BUSY          (BUSY),
    .DONE          (DONE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] norm(input logic [W-1:0] r);
    return (r == 0) ? 8'd1 : r;
  endfunction

  // Expected {ratio, en, cnt_rst_n, busy, done, ready} at cycle k after an accept that changes the ratio.
  function automatic logic [12:0] exp_full(input int k, input logic [W-1:0] old_r,
                                           input logic [W-1:0] new_r, input logic en_prev);
    if (k <= G)              return {old_r, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    else if (k == G + 1)     return {new_r, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    else if (k <= 2 * G + 1) return {new_r, en_prev, 1'b1, 1'b1, 1'b0, 1'b0};
    else                     return {new_r, en_prev, 1'b1, 1'b0, 1'b1, 1'b1};
  endfunction

  function automatic logic [12:0] observed();
    return {DIV_RATIO, DIV_CLK_EN, DIV_CNT_RST_N, BUSY, DONE, CFG_READY};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Called in a cycle where CFG_READY=1; that cycle is the accept cycle 0.
  // en_mode: 0 hold EN_REQ, 1 random each cycle, 2 drop EN_REQ in cycle 2 (GATE).
  task automatic run_seq(input logic [W-1:0] req, input int en_mode,
                         input bit hold_next, input logic [W-1:0] next_r);
    logic [W-1:0] n;
    logic [W-1:0] old;
    logic [12:0]  exp;
    logic [12:0]  act;
    logic         en_prev;
    int           last;
    n         = norm(req);
    old       = model_ratio;
    CFG_VALID = 1'b1;
    CFG_RATIO = req;
    en_prev   = EN_REQ;
    last      = (n == old) ? 3 : 2 * G + 2;
    for (int k = 1; k <= last; k++) begin
      step();
      if (n == old) exp = {old, en_prev, 1'b1, 1'b0, (k == 1), 1'b1};
      else          exp = exp_full(k, old, n, en_prev);
      act = observed();
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL seq req=%0d cyc=%0d got=%h want=%h", req, k, act, exp);
      end
      if (k == 1) CFG_VALID = 1'b0;
      if (hold_next && k == 2) begin
        CFG_VALID = 1'b1;
        CFG_RATIO = next_r;
      end
      case (en_mode)
        1:       EN_REQ = 1'($urandom_range(0, 1));
        2:       if (k == 2) EN_REQ = 1'b0;
        default: ;
      endcase
      en_prev = EN_REQ;
    end
    model_ratio = n;
  endtask

  task automatic test_reset();
    logic [12:0] act;
    RST       = 1'b1;
    EN_REQ    = 1'b0;
    CFG_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      act = observed();
      total++;
      if (act !== 13'h0_10_8 >> 0 && act !== {8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, act, {8'd1, 5'b01000});
      end
    end
    RST = 1'b0;
    step();
    act = observed();
    total++;
    if (act !== {8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_release got=%h want=%h", act, {8'd1, 5'b01001});
    end
    model_ratio = 8'd1;
  endtask

  task automatic test_ratio_change();
    EN_REQ = 1'b1;
    run_seq(8'd6, 0, 1'b0, 8'd0);
  endtask

  task automatic test_same_ratio();
    run_seq(8'd6, 0, 1'b0, 8'd0);
  endtask

  task automatic test_zero_ratio();
    run_seq(8'd0, 0, 1'b0, 8'd0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] first;
    first  = W'(7 + $urandom_range(0, 5));
    EN_REQ = 1'b1;
    run_seq(first, 2, 1'b1, 8'd5);
    run_seq(8'd5, 0, 1'b0, 8'd0);
  endtask

  task automatic test_random();
    logic [W-1:0] req;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) req = model_ratio;
      else                           req = W'($urandom_range(0, 15));
      run_seq(req, 1, 1'b0, 8'd0);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] n;
    logic [W-1:0] old;
    logic [12:0]  exp;
    logic [12:0]  act;
    old       = model_ratio;
    n         = old + 8'd3;
    EN_REQ    = 1'b1;
    CFG_VALID = 1'b1;
    CFG_RATIO = n;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp = exp_full(k, old, n, 1'b1);
      act = observed();
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL rst_mid_seq cyc=%0d got=%h want=%h", k, act, exp);
      end
      CFG_VALID = 1'b0;
    end
    RST = 1'b1;
    step();
    act = observed();
    total++;
    if (act !== {8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rst_mid_abort got=%h want=%h", act, {8'd1, 5'b01000});
    end
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      act = observed();
      total++;
      if (act !== {8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL rst_mid_after cyc=%0d got=%h want=%h", k, act, {8'd1, 5'b11001});
      end
    end
    model_ratio = 8'd1;
  endtask

  initial begin
    test_reset();
    test_ratio_change();
    test_same_ratio();
    test_zero_ratio();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clkdiv_ratio_ctrl.md
# clkdiv_ratio_ctrl

Control stage that sits directly upstream of the integer clock divider and owns its `DIV_RATIO`, `CLK_EN` and local counter-reset inputs. It accepts ratio-change requests from the register file over a valid/ready handshake. It then sequences a glitch-safe reconfiguration: gate the divider, load the new ratio, restart the divider counter, re-enable, and report completion. This keeps the divider's counter from ever being compared against a ratio that changed mid-period.

## Interface
- `RATIO_WIDTH`, 8: width of the ratio bus; must match the divider.
- `GUARD_CYCLES`, 4: CLK cycles held in each of GATE and RESUME; legal range 1..255.
- `DEFAULT_RATIO`, 1: ratio driven out of reset (1 = bypass).
- `CLK` in 1: system clock, same clock as the divider.
- `RST` in 1: synchronous, active-high reset (one clock, `CLK`; reset is synchronous and active-high).
- `CFG_VALID` in 1: new-ratio request valid.
- `CFG_RATIO` in RATIO_WIDTH: requested division ratio.
- `CFG_READY` out 1: controller can accept a request.
- `EN_REQ` in 1: system wants the divided clock enabled.
- `DIV_RATIO` out RATIO_WIDTH: ratio driven to the divider.
- `DIV_CLK_EN` out 1: clock enable driven to the divider.
- `DIV_CNT_RST_N` out 1: active-low counter restart to the divider, pulsed for one cycle.
- `BUSY` out 1: reconfiguration in progress.
- `DONE` out 1: one-cycle pulse when a request completes.

## Operation
- States are IDLE, GATE, LOAD and RESUME. All outputs are registered.
- **IDLE**
  - `CFG_READY`=1, `BUSY`=0.
  - `DIV_CLK_EN` follows `EN_REQ` with 1-cycle register delay.
- **Accept:** a request is accepted on the `CFG_VALID`&&`CFG_READY` edge. The ratio is normalised before use: 0 is coerced to 1, both meaning bypass.
- **Same-ratio request:** if the normalised ratio equals the current `DIV_RATIO`, stay in IDLE and pulse `DONE` next cycle. There is no gating and no counter restart.
- **GATE**
  - `DIV_CLK_EN`=0 and `CFG_READY`=0, `BUSY`=1.
  - A guard counter loads `GUARD_CYCLES`-1 and counts down; exit to LOAD at 0.
- **LOAD** (1 cycle): `DIV_RATIO`<=new ratio, `DIV_CNT_RST_N`=0, `DIV_CLK_EN`=0.
- **RESUME**
  - `DIV_CLK_EN`=latest `EN_REQ` and `DIV_CNT_RST_N`=1.
  - Guard counter as in GATE. On exit, pulse `DONE`, return to IDLE, `CFG_READY`=1.
- **`EN_REQ` changes:** during GATE/LOAD the change is ignored until RESUME. During RESUME it is tracked cycle by cycle.
- **`CFG_VALID` while busy:** the request is not accepted and must be held by the source. Valid/ready semantics: `CFG_RATIO` must stay stable while `CFG_VALID`=1 and `CFG_READY`=0.
- **Reset mid-operation:** aborts to IDLE immediately.

## Timing
- Reset values:
  - `DIV_RATIO`=`DEFAULT_RATIO`, `DIV_CLK_EN`=0, `DIV_CNT_RST_N`=1.
  - `BUSY`=0, `DONE`=0.
  - `CFG_READY`=0 during reset, 1 from the first cycle after `RST` deasserts.
- With the accept edge at cycle 0 and G=`GUARD_CYCLES`:
  - GATE spans cycles 1..G; `DIV_CLK_EN`=0 from cycle 1.
  - LOAD is cycle G+1.
  - RESUME spans cycles G+2..2G+1.
  - `DONE`=1 and `CFG_READY`=1 in cycle 2G+2.
  - Total 2G+2 cycles.
- Same-ratio path: `DONE` at cycle 1, `CFG_READY` never drops.
- `DONE` and a new accept may coincide in the same cycle; the new request starts its own sequence.
- Ratio compare and store are full RATIO_WIDTH unsigned. Guard counter is 8 bits; it does not wrap because the load value is ≤254.

## Structure
- Package `clkdiv_pkg` holds:
  - the `clkdiv_ctrl_state_t` enum (IDLE, GATE, LOAD, RESUME);
  - `CLKDIV_BYPASS_RATIO` = 1;
  - the default `GUARD_CYCLES`.
- One sub-module, `clkdiv_guard_cnt`: an 8-bit loadable down-counter with a `zero` flag, instantiated once and reused by GATE and RESUME.
- The top level holds the FSM, ratio register, normalisation and output registers.

## Test plan
All scenarios use G=4.
- **Reset:** hold `RST`=1 for 3 cycles with `DEFAULT_RATIO`=1 → `DIV_RATIO`=1, `DIV_CLK_EN`=0, `CFG_READY`=0. Deassert → `CFG_READY`=1 next cycle.
- **Ratio change:** `EN_REQ`=1, then request ratio 6 → `DIV_CLK_EN`=0 over cycles 1–4. Cycle 5 has `DIV_RATIO`=6 and `DIV_CNT_RST_N`=0. `DIV_CLK_EN`=1 over cycles 6–9. `DONE` pulses in cycle 10.
- **Same ratio:** with current ratio 6, request 6 → `DONE` at cycle 1, `DIV_CLK_EN` stays 1, no `DIV_CNT_RST_N` pulse.
- **Zero ratio:** request ratio 0 → `DIV_RATIO`=1 after LOAD and the full 10-cycle sequence runs.
- **Back-pressure and `EN_REQ` during GATE:**
  - Assert `CFG_VALID`=1 with ratio 5 during GATE of a prior request → not accepted until `CFG_READY`=1, then a second sequence yields `DIV_RATIO`=5.
  - Drop `EN_REQ` during GATE → `DIV_CLK_EN`=0 throughout RESUME.
- **Reset mid-RESUME:** assert `RST` in cycle 7 → next cycle IDLE, `DIV_RATIO`=`DEFAULT_RATIO`, `DIV_CLK_EN`=0, no `DONE`.
